hazard_mdu_unit: RTL and testbench
==================================

# hazard_mdu_unit

Parametrised successor to the pipeline hazard unit. It keeps EX-stage forwarding, load-use stalling and branch flushing, and adds two things. First, load-use detection is qualified by register use and excludes x0. Second, it adds a sequential stall controller for a multi-cycle multiply/divide unit (MDU) that holds an MDU instruction in Execute for `MDU_LAT` cycles. It sits beside the five-stage datapath and drives all stall/flush enables of the F/D, D/E and E/M pipeline registers.

## Interface
Parameters:
- `REG_AW`, 5 — register address width.
- `MDU_LAT`, 4 — cycles an MDU op occupies Execute; legal range 2..16.
- `CNT_W`, 32 — perf counter width (used only with `HAZARD_PERF_EN`).

Ports:
- `clk`  in  1 — single clock, rising edge.
- `rst_n`  in  1 — reset, asynchronous, active-low.
- `Rs1D`, `Rs2D`  in  REG_AW — source registers in Decode.
- `UseRs1D`, `UseRs2D`  in  1 — Decode instruction actually reads Rs1/Rs2.
- `Rs1E`, `Rs2E`, `RdE`  in  REG_AW — Execute source/destination registers.
- `RdM`, `RdW`  in  REG_AW — Memory/Writeback destination registers.
- `RegWriteM`, `RegWriteW`  in  1 — writeback enables.
- `ResultSrcE0`  in  1 — Execute instruction is a load.
- `PCSrcE`  in  1 — taken branch/jump resolved in Execute.
- `MduStartE`  in  1 — Execute holds a valid MDU instruction.
- `ForwardAE`, `ForwardBE`  out  2 — 00 regfile, 01 from W, 10 from M.
- `StallF`, `StallD`, `StallE`  out  1 — hold pipeline registers.
- `FlushD`, `FlushE`, `FlushM`  out  1 — bubble into the register.
- `MduBusy`  out  1 — FSM in BUSY.
- `MduLastE`  out  1 — final Execute cycle of the MDU op; result is valid.
- `LoadStallCnt`, `MduStallCnt`, `FlushCnt`  out  CNT_W — perf counters (`HAZARD_PERF_EN` only).

## Operation
- Forwarding (combinational), per operand:
  - 10 if `RsxE == RdM`, `RegWriteM` is set and `RsxE != 0`.
  - Else 01 if `RsxE == RdW`, `RegWriteW` is set and `RsxE != 0`.
  - Else 00. M has priority over W.
- Load stall, `loadStall`: `ResultSrcE0 & RdE != 0 & ((UseRs1D & Rs1D == RdE) | (UseRs2D & Rs2D == RdE))`.
- MDU FSM states and transitions:
  - IDLE: `MduStartE` moves to BUSY and loads `cnt = MDU_LAT-2`.
  - BUSY: `cnt` decrements each cycle. When `cnt == 0`, `MduLastE = 1` and the FSM returns to IDLE.
- `mduStall` = (IDLE & `MduStartE`) | (BUSY & `cnt != 0`).
- Output equations:
  - `StallE` = `mduStall`.
  - `StallF` = `StallD` = (`loadStall` | `mduStall`) & !`PCSrcE`.
  - `FlushM` = `mduStall`.
  - `FlushD` = `PCSrcE`.
  - `FlushE` = `PCSrcE` | (`loadStall` & !`mduStall`).
- `MduStartE` and `PCSrcE` are never high together (MDU ops are not control flow). The bench asserts this.
- `MduStartE` during BUSY is the same instruction and is ignored by the FSM.

## Timing
- Forwarding, stall and flush outputs are combinational, with zero latency from inputs.
- An MDU op entering E in cycle t:
  - Stalls are high in t..t+MDU_LAT-2.
  - `MduLastE` is high in t+MDU_LAT-1.
  - The op advances to M at the end of t+MDU_LAT-1.
- Reset values:
  - FSM is IDLE, `cnt` = 0, `MduBusy` = 0, `MduLastE` = 0, all perf counters 0.
  - Combinational outputs follow inputs with the FSM in IDLE.
- Reset asserted mid-op aborts to IDLE immediately. The datapath is reset concurrently.
- Back-to-back MDU ops: the second enters E the cycle after `MduLastE` and restarts the FSM from IDLE with no gap cycle.
- Load-use hazard behind a stalled MDU op: D stays held through the MDU stall. `FlushE` is suppressed while `mduStall` is high, so the MDU op is not squashed. The load-use bubble is inserted afterward.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Three saturating CNT_W counters exist.
  - They increment on cycles with `loadStall & !PCSrcE`, on `mduStall` cycles, and on `FlushD` cycles respectively.
- `HAZARD_PERF_EN` undefined: the counter ports and logic are absent.

## Structure
- Shared package `hazard_pkg` holds:
  - Forward-select constants `FWD_RF` = 00, `FWD_W` = 01, `FWD_M` = 10.
  - MDU FSM state typedef `mdu_state_t` {IDLE, BUSY}.
- Sub-module `mdu_stall_fsm` holds the FSM, `cnt`, and the `mduStall`/`MduLastE` generation. Top-level logic holds forwarding, load detection and output combining.

## Test plan
- Forwarding:
  - `Rs1E` = 5, `RdM` = 5 with `RegWriteM`, and `RdW` = 5 with `RegWriteW` -> `ForwardAE` = 10.
  - `Rs2E` = 0 with `RdM` = 0 -> `ForwardBE` = 00.
- Load-use:
  - Load with `RdE` = 7, `Rs2D` = 7, `UseRs2D` = 1 -> `StallF`/`StallD`/`FlushE` = 1 for one cycle.
  - Same with `UseRs2D` = 0 -> no stall.
- MDU latency (`MDU_LAT` = 4):
  - `MduStartE` at t -> `StallE`/`FlushM` high t..t+2, `MduLastE` at t+3, `MduBusy` t+1..t+3.
- Branch priority: `PCSrcE` with `loadStall` -> `StallF` = 0, `FlushD` = `FlushE` = 1.
- Reset mid-op: `rst_n` low at t+1 of an MDU op -> `MduBusy` = 0 asynchronously, no `MduLastE`.
- Perf (`HAZARD_PERF_EN`): one MDU op with `MDU_LAT` = 4 plus one load stall -> `MduStallCnt` = 3, `LoadStallCnt` = 1.

Source files
------------

// File: rtl/hazard_mdu_unit_pkg.sv
// Shared types and constants for the hazard unit with MDU stall control (package hazard_pkg).
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Wide enough for MDU_LAT-2 with MDU_LAT up to 16.
  localparam int MDU_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_mdu_unit_if.sv
// Datapath <-> hazard unit bundle. Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_mdu_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic              UseRs1D, UseRs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              MduStartE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              MduBusy;
  logic              MduLastE;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]  LoadStallCnt, MduStallCnt, FlushCnt;
`endif

  // The datapath drives pipeline state in; the hazard unit drives control out.
  modport master (
    output Rs1D, Rs2D, UseRs1D, UseRs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MduStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MduBusy, MduLastE
`ifdef HAZARD_PERF_EN
   ,input  LoadStallCnt, MduStallCnt, FlushCnt
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, UseRs1D, UseRs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MduStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MduBusy, MduLastE
`ifdef HAZARD_PERF_EN
   ,output LoadStallCnt, MduStallCnt, FlushCnt
`endif
  );

endinterface

// File: rtl/hazard_mdu_unit_mdu_fsm.sv
// Holds an MDU instruction in Execute for MDU_LAT cycles; mdu_last_o marks the result-valid cycle.
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mdu_start_i,
  output logic                 mdu_stall_o,
  output logic                 mdu_last_o,
  output logic                 mdu_busy_o,
  output mdu_state_t           state_o,
  output logic [MDU_CNT_W-1:0] cnt_o
);

  localparam logic [MDU_CNT_W-1:0] CNT_INIT = MDU_CNT_W'(MDU_LAT - 2);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);

  mdu_state_t           state_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic                 busy_q, last_q, hold_q;

  // hold_q registers "BUSY and cnt != 0" so the BUSY part of the stall is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_start_i) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            last_q  <= (CNT_INIT == '0);
            hold_q  <= (CNT_INIT != '0);
          end
        end
        BUSY: begin
          // MduStartE stays high while the same op is held; it is not a new start.
          if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_ONE;
            last_q <= (cnt_q == CNT_ONE);
            hold_q <= (cnt_q != CNT_ONE);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          last_q  <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_stall_o = ((state_q == IDLE) && mdu_start_i) || hold_q;
  assign mdu_last_o  = last_q;
  assign mdu_busy_o  = busy_q;
  assign state_o     = state_q;
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/hazard_mdu_unit.sv
// Forwarding, load-use stall, branch flush and MDU stall combining for the five-stage pipeline.
// Optional saturating perf counters are built when HAZARD_PERF_EN is defined.
module hazard_mdu_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_mdu_if.slave          hz,
  output mdu_state_t           mdu_state_o,
  output logic [MDU_CNT_W-1:0] mdu_cnt_o
);

  logic [1:0] fwd_a, fwd_b;
  logic       load_stall;
  logic       mdu_stall;
  logic       mdu_last, mdu_busy;

  // M has priority over W since it carries the younger result; x0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    if (hz.RegWriteM && (hz.Rs1E == hz.RdM) && (hz.Rs1E != '0))
      fwd_a = FWD_M;
    else if (hz.RegWriteW && (hz.Rs1E == hz.RdW) && (hz.Rs1E != '0))
      fwd_a = FWD_W;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (hz.RegWriteM && (hz.Rs2E == hz.RdM) && (hz.Rs2E != '0))
      fwd_b = FWD_M;
    else if (hz.RegWriteW && (hz.Rs2E == hz.RdW) && (hz.Rs2E != '0))
      fwd_b = FWD_W;
  end

  assign load_stall = hz.ResultSrcE0 && (hz.RdE != '0) &&
                      ((hz.UseRs1D && (hz.Rs1D == hz.RdE)) ||
                       (hz.UseRs2D && (hz.Rs2D == hz.RdE)));

  mdu_stall_fsm #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .mdu_start_i (hz.MduStartE),
    .mdu_stall_o (mdu_stall),
    .mdu_last_o  (mdu_last),
    .mdu_busy_o  (mdu_busy),
    .state_o     (mdu_state_o),
    .cnt_o       (mdu_cnt_o)
  );

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallE    = mdu_stall;
  assign hz.StallF    = (load_stall || mdu_stall) && !hz.PCSrcE;
  assign hz.StallD    = (load_stall || mdu_stall) && !hz.PCSrcE;
  assign hz.FlushM    = mdu_stall;
  assign hz.FlushD    = hz.PCSrcE;
  // Squashing E while the MDU op is held would kill it; the load bubble waits until it leaves.
  assign hz.FlushE    = hz.PCSrcE || (load_stall && !mdu_stall);
  assign hz.MduBusy   = mdu_busy;
  assign hz.MduLastE  = mdu_last;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] load_cnt_q, mdu_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      mdu_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_stall && !hz.PCSrcE && (load_cnt_q != '1))
        load_cnt_q <= load_cnt_q + 1'b1;
      if (mdu_stall && (mdu_cnt_q != '1))
        mdu_cnt_q <= mdu_cnt_q + 1'b1;
      if (hz.PCSrcE && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.LoadStallCnt = load_cnt_q;
  assign hz.MduStallCnt  = mdu_cnt_q;
  assign hz.FlushCnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_mdu_unit.sv
// Directed bench for hazard_mdu_unit (MDU_LAT = 4); perf counter checks build with HAZARD_PERF_EN.
module tb_hazard_mdu_unit;
  import hazard_pkg::*;

  localparam int REG_AW  = 5;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  logic                 clk;
  logic                 rst_n;
  mdu_state_t           dbg_state;
  logic [MDU_CNT_W-1:0] dbg_cnt;
  int                   n_checks;
  int                   n_fail;

  hazard_mdu_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_mdu_unit #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hz          (hz.slave),
    .mdu_state_o (dbg_state),
    .mdu_cnt_o   (dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(hz.MduStartE && hz.PCSrcE))
        else $error("MduStartE and PCSrcE high together");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.UseRs1D = 1'b0; hz.UseRs2D = 1'b0;
    hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
    hz.PCSrcE = 1'b0; hz.MduStartE = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_mdu(input string tag, input logic stall, input logic busy, input logic last);
    check({tag, ".StallE"},   {31'b0, hz.StallE},   {31'b0, stall});
    check({tag, ".FlushM"},   {31'b0, hz.FlushM},   {31'b0, stall});
    check({tag, ".StallF"},   {31'b0, hz.StallF},   {31'b0, stall});
    check({tag, ".MduBusy"},  {31'b0, hz.MduBusy},  {31'b0, busy});
    check({tag, ".MduLastE"}, {31'b0, hz.MduLastE}, {31'b0, last});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst.state", 32'(dbg_state), 32'(IDLE));
    check("rst.cnt", 32'(dbg_cnt), 32'd0);
    check_mdu("rst", 1'b0, 1'b0, 1'b0);
    check("rst.FlushD", {31'b0, hz.FlushD}, 32'd0);
    check("rst.FlushE", {31'b0, hz.FlushE}, 32'd0);
    check("rst.ForwardAE", 32'(hz.ForwardAE), 32'd0);
`ifdef HAZARD_PERF_EN
    check("rst.MduStallCnt", hz.MduStallCnt, 32'd0);
`endif
    rst_n = 1'b1;

    // single MDU op: stall t..t+2, last at t+3, busy t+1..t+3
    step(); hz.MduStartE = 1'b1; settle();
    check_mdu("mdu.t0", 1'b1, 1'b0, 1'b0);
    step(); settle();
    check_mdu("mdu.t1", 1'b1, 1'b1, 1'b0);
    check("mdu.t1.cnt", 32'(dbg_cnt), 32'd2);
    step(); settle();
    check_mdu("mdu.t2", 1'b1, 1'b1, 1'b0);
    step(); settle();
    check_mdu("mdu.t3", 1'b0, 1'b1, 1'b1);
    check("mdu.t3.StallD", {31'b0, hz.StallD}, 32'd0);
    step(); hz.MduStartE = 1'b0; settle();
    check_mdu("mdu.t4", 1'b0, 1'b0, 1'b0);
    check("mdu.t4.state", 32'(dbg_state), 32'(IDLE));

    // load-use on Rs2
    step();
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.UseRs2D = 1'b1;
    settle();
    check("ld.StallF", {31'b0, hz.StallF}, 32'd1);
    check("ld.StallD", {31'b0, hz.StallD}, 32'd1);
    check("ld.FlushE", {31'b0, hz.FlushE}, 32'd1);
    check("ld.StallE", {31'b0, hz.StallE}, 32'd0);
    step(); clear_inputs(); settle();
    check("ld.after.StallF", {31'b0, hz.StallF}, 32'd0);
    check("ld.after.FlushE", {31'b0, hz.FlushE}, 32'd0);

    // register not read: no stall
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.UseRs2D = 1'b0;
    settle();
    check("ld.nouse.StallF", {31'b0, hz.StallF}, 32'd0);
    check("ld.nouse.FlushE", {31'b0, hz.FlushE}, 32'd0);
    // load to x0: no stall
    hz.RdE = 5'd0; hz.Rs1D = 5'd0; hz.UseRs1D = 1'b1; hz.Rs2D = 5'd0; hz.UseRs2D = 1'b1;
    settle();
    check("ld.x0.StallD", {31'b0, hz.StallD}, 32'd0);
    // Rs1 match
    hz.RdE = 5'd12; hz.Rs1D = 5'd12; hz.Rs2D = 5'd3;
    settle();
    check("ld.rs1.StallD", {31'b0, hz.StallD}, 32'd1);
    hz.ResultSrcE0 = 1'b0;
    settle();
    check("ld.notload.StallD", {31'b0, hz.StallD}, 32'd0);
    clear_inputs();

`ifdef HAZARD_PERF_EN
    step(); settle();
    check("perf.MduStallCnt", hz.MduStallCnt, 32'd3);
    check("perf.LoadStallCnt", hz.LoadStallCnt, 32'd1);
    check("perf.FlushCnt", hz.FlushCnt, 32'd0);
`endif

    // forwarding
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    settle();
    check("fwd.a.m_over_w", 32'(hz.ForwardAE), 32'(2'b10));
    hz.RegWriteM = 1'b0;
    settle();
    check("fwd.a.w", 32'(hz.ForwardAE), 32'(2'b01));
    hz.RegWriteW = 1'b0;
    settle();
    check("fwd.a.rf", 32'(hz.ForwardAE), 32'(2'b00));
    hz.Rs2E = 5'd0; hz.RdM = 5'd0; hz.RegWriteM = 1'b1; hz.RdW = 5'd0; hz.RegWriteW = 1'b1;
    settle();
    check("fwd.b.x0", 32'(hz.ForwardBE), 32'(2'b00));
    hz.Rs2E = 5'd9; hz.RdM = 5'd4; hz.RdW = 5'd9;
    settle();
    check("fwd.b.w", 32'(hz.ForwardBE), 32'(2'b01));
    hz.RdM = 5'd9;
    settle();
    check("fwd.b.m", 32'(hz.ForwardBE), 32'(2'b10));
    clear_inputs();

    // branch beats load stall
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.UseRs2D = 1'b1; hz.PCSrcE = 1'b1;
    settle();
    check("br.StallF", {31'b0, hz.StallF}, 32'd0);
    check("br.StallD", {31'b0, hz.StallD}, 32'd0);
    check("br.FlushD", {31'b0, hz.FlushD}, 32'd1);
    check("br.FlushE", {31'b0, hz.FlushE}, 32'd1);
    check("br.StallE", {31'b0, hz.StallE}, 32'd0);
    step(); clear_inputs(); settle();

    // back-to-back MDU ops with no gap cycle
    hz.MduStartE = 1'b1; settle();
    check_mdu("b2b.a.t0", 1'b1, 1'b0, 1'b0);
    step(); step(); step(); settle();
    check_mdu("b2b.a.t3", 1'b0, 1'b1, 1'b1);
    step(); settle();
    check_mdu("b2b.b.t0", 1'b1, 1'b0, 1'b0);
    step(); settle();
    check_mdu("b2b.b.t1", 1'b1, 1'b1, 1'b0);
    step(); step(); settle();
    check_mdu("b2b.b.t3", 1'b0, 1'b1, 1'b1);
    step(); hz.MduStartE = 1'b0; settle();
    check_mdu("b2b.done", 1'b0, 1'b0, 1'b0);

    // load-use behind a held MDU op
    hz.MduStartE = 1'b1;
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd8; hz.Rs1D = 5'd8; hz.UseRs1D = 1'b1;
    settle();
    check("mld.t0.FlushE", {31'b0, hz.FlushE}, 32'd0);
    check("mld.t0.StallD", {31'b0, hz.StallD}, 32'd1);
    check("mld.t0.StallE", {31'b0, hz.StallE}, 32'd1);
    step(); step(); settle();
    check("mld.t2.FlushE", {31'b0, hz.FlushE}, 32'd0);
    step(); settle();
    check("mld.t3.FlushE", {31'b0, hz.FlushE}, 32'd1);
    check("mld.t3.StallD", {31'b0, hz.StallD}, 32'd1);
    check("mld.t3.MduLastE", {31'b0, hz.MduLastE}, 32'd1);
    step(); clear_inputs(); settle();

    // reset mid-op aborts asynchronously
    hz.MduStartE = 1'b1;
    step(); settle();
    check("rmid.t1.MduBusy", {31'b0, hz.MduBusy}, 32'd1);
    hz.MduStartE = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rmid.MduBusy", {31'b0, hz.MduBusy}, 32'd0);
    check("rmid.state", 32'(dbg_state), 32'(IDLE));
    check("rmid.cnt", 32'(dbg_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      check($sformatf("rmid.nolast%0d", i), {31'b0, hz.MduLastE}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
